// File: rtl/imem_fetch_if.sv
// Fetch/load bus for the instruction memory.
// slave = memory side, master = fetch stage / loader.
interface imem_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              load_mode;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  load_mode, load_we, load_addr, load_data,
    input  req_valid, req_addr, rsp_ready,
    output load_err, req_ready, rsp_valid,
    output rsp_instr, rsp_err, busy
  );

  modport master (
    output load_mode, load_we, load_addr, load_data,
    output req_valid, req_addr, rsp_ready,
    input  load_err, req_ready, rsp_valid,
    input  rsp_instr, rsp_err, busy
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction memory with registered read behind a
// valid/ready fetch handshake and a program-load port.
module imem_fetch_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8,
  parameter logic [DATA_W-1:0] NOP_WORD =
    DATA_W'(32'h00000013)
) (
  input logic         clk,
  input logic         rst_n,
  imem_fetch_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int unsigned LIM = 4 * DEPTH;

  typedef enum logic {
    S_RUN,
    S_LOAD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_instr;
  logic              r_rsp_err;
  logic              r_load_err;

  logic             w_pend;
  logic             w_ready;
  logic             w_acc;
  logic             w_rfault;
  logic             w_lfault;
  logic             w_wr;
  logic             w_lrej;
  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_lidx;

  assign w_pend   = r_rsp_valid & ~bus.rsp_ready;
  assign w_ridx   = bus.req_addr[IDX_W+1:2];
  assign w_lidx   = bus.load_addr[IDX_W+1:2];
  assign w_rfault = (bus.req_addr[1:0] != 2'b00) |
                    (32'(bus.req_addr) >= LIM);
  assign w_lfault = (bus.load_addr[1:0] != 2'b00) |
                    (32'(bus.load_addr) >= LIM);
  assign w_acc    = bus.req_valid & w_ready;
  assign w_wr     = (r_state == S_LOAD) &
                    bus.load_we & ~w_lfault;
  assign w_lrej   = (r_state == S_LOAD) &
                    bus.load_we & w_lfault;

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Mode transitions; LOAD waits for a stalled response to drain.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    unique case (r_state)
      S_RUN: begin
        w_ready = ~bus.load_mode & ~w_pend;
        if (bus.load_mode && !w_pend)
          w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!bus.load_mode)
          w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Response register; faulting fetches skip the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= NOP_WORD;
      r_rsp_err   <= 1'b0;
    end else if (w_acc) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_rfault;
      if (w_rfault) r_rsp_instr <= NOP_WORD;
      else          r_rsp_instr <= r_mem[w_ridx];
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // One-cycle flag for a rejected load write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_load_err <= 1'b0;
    else        r_load_err <= w_lrej;
  end

  // Program storage; survives reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_lidx] <= bus.load_data;
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_instr = r_rsp_instr;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.load_err  = r_load_err;
  assign bus.busy      = (r_state == S_LOAD);
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed plan plus random
// traffic against a cycle-level behavioural model.
module tb_imem_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_if #(.DATA_W(32), .ADDR_W(9))  b1 ();
  imem_fetch_if #(.DATA_W(32), .ADDR_W(10)) b2 ();

  imem_fetch_unit #(
    .DATA_W(32), .DEPTH(64), .ADDR_W(9)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  imem_fetch_unit #(
    .DATA_W(32), .DEPTH(256), .ADDR_W(10)
  ) u_dut_big (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] m_mem [64];
  bit          m_kn  [64];
  bit          m_valid, m_err, m_load, m_lerr, m_rkn;
  logic [31:0] m_instr;

  logic [31:0] s_instr;
  logic        s_valid, s_err, s_ready, s_busy, s_lerr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  function automatic bit flt(input logic [8:0] a);
    return (a[1:0] != 2'b00) || (a >= 9'h100);
  endfunction

  task automatic m_reset();
    m_valid = 0;
    m_err   = 0;
    m_load  = 0;
    m_lerr  = 0;
    m_rkn   = 1;
    m_instr = NOP;
  endtask

  task automatic drive(input logic lm, we,
                       input logic [8:0] la,
                       input logic [31:0] ld,
                       input logic rv,
                       input logic [8:0] ra,
                       input logic rr);
    b1.load_mode = lm;
    b1.load_we   = we;
    b1.load_addr = la;
    b1.load_data = ld;
    b1.req_valid = rv;
    b1.req_addr  = ra;
    b1.rsp_ready = rr;
  endtask

  // One clock: drive, check against model, advance model.
  task automatic step(input logic lm, we,
                      input logic [8:0] la,
                      input logic [31:0] ld,
                      input logic rv,
                      input logic [8:0] ra,
                      input logic rr);
    bit pend, rdy;
    @(negedge clk);
    drive(lm, we, la, ld, rv, ra, rr);
    #1;
    s_instr = b1.rsp_instr;
    s_valid = b1.rsp_valid;
    s_err   = b1.rsp_err;
    s_ready = b1.req_ready;
    s_busy  = b1.busy;
    s_lerr  = b1.load_err;
    pend = m_valid && !rr;
    rdy  = !m_load && !lm && !pend;
    chk("req_ready", s_ready, rdy);
    chk("rsp_valid", s_valid, m_valid);
    chk("rsp_err", s_err, m_err);
    if (m_rkn) chk("rsp_instr", s_instr, m_instr);
    chk("busy", s_busy, m_load);
    chk("load_err", s_lerr, m_lerr);
    m_lerr = m_load && we && flt(la);
    if (m_load && we && !flt(la)) begin
      m_mem[la[7:2]] = ld;
      m_kn[la[7:2]]  = 1;
    end
    if (rv && rdy) begin
      m_valid = 1;
      if (flt(ra)) begin
        m_instr = NOP;
        m_err   = 1;
        m_rkn   = 1;
      end else begin
        m_instr = m_mem[ra[7:2]];
        m_err   = 0;
        m_rkn   = m_kn[ra[7:2]];
      end
    end else if (rr) begin
      m_valid = 0;
    end
    m_load = m_load ? lm : (lm && !pend);
  endtask

  task automatic fetch(input logic [8:0] a);
    step(0, 0, 0, 0, 1, a, 1);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  // Reset pulled low between edges.
  task automatic async_rst(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, b1.rsp_valid, 0);
    chk({tag, "_busy"}, b1.busy, 0);
    chk({tag, "_lerr"}, b1.load_err, 0);
    chk({tag, "_instr"}, b1.rsp_instr, NOP);
    m_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic lm;
    logic [8:0] la, ra;
    logic [31:0] r;
    for (int i = 0; i < 64; i++) m_kn[i] = 0;
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    b2.load_mode = 0;
    b2.load_we   = 0;
    b2.load_addr = '0;
    b2.load_data = '0;
    b2.req_valid = 0;
    b2.req_addr  = '0;
    b2.rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", b1.rsp_valid, 0);
    chk("rst_instr", b1.rsp_instr, NOP);
    chk("rst_err", b1.rsp_err, 0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_lerr", b1.load_err, 0);
    rst_n = 1'b1;

    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 9'h000, 32'h09300313, 0, 0, 1);
    step(1, 1, 9'h004, 32'h00100393, 0, 0, 1);
    step(1, 1, 9'h008, 32'h00d00e13, 0, 0, 1);
    for (int i = 3; i < 64; i++)
      step(1, 1, 9'(i * 4), $urandom, 0, 0, 1);
    step(1, 1, 9'h002, 32'hbadbad00, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("lerr_pulse", s_lerr, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("lerr_clear", s_lerr, 0);
    step(0, 0, 0, 0, 1, 0, 1);

    fetch(9'h000);
    fetch(9'h004);
    chk("bb0", s_instr, 32'h09300313);
    fetch(9'h008);
    chk("bb1", s_instr, 32'h00100393);
    idle();
    chk("bb2", s_instr, 32'h00d00e13);
    chk("bb2_err", s_err, 0);
    idle();
    chk("drain", s_valid, 0);

    fetch(9'h006);
    fetch(9'h100);
    chk("f06_instr", s_instr, NOP);
    chk("f06_err", s_err, 1);
    fetch(9'h000);
    chk("f100_instr", s_instr, NOP);
    chk("f100_err", s_err, 1);
    idle();
    chk("no_alias", s_instr, 32'h09300313);

    fetch(9'h004);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, 9'h008, 0);
      chk("bp_ready", s_ready, 0);
      chk("bp_instr", s_instr, 32'h00100393);
    end
    step(0, 0, 0, 0, 1, 9'h008, 1);
    chk("bp_release", s_ready, 1);
    idle();
    chk("bp_next", s_instr, 32'h00d00e13);

    fetch(9'h000);
    step(1, 1, 9'h000, 32'hdeadbeef, 1, 9'h004, 0);
    chk("il_busy0", s_busy, 0);
    step(1, 1, 9'h000, 32'hdeadbeef, 1, 9'h004, 0);
    chk("il_busy1", s_busy, 0);
    step(1, 1, 9'h000, 32'hdeadbeef, 1, 9'h004, 1);
    chk("il_busy2", s_busy, 0);
    step(1, 0, 0, 0, 1, 9'h004, 0);
    chk("il_busy3", s_busy, 1);
    chk("il_ready", s_ready, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    fetch(9'h000);
    idle();
    chk("we_in_run", s_instr, 32'h09300313);

    fetch(9'h004);
    fetch(9'h008);
    async_rst("arst_fetch");
    idle();
    fetch(9'h000);
    idle();
    chk("post_rst", s_instr, 32'h09300313);

    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 9'h00c, 32'h12345678, 0, 0, 1);
    async_rst("arst_load");
    idle();
    fetch(9'h00c);
    idle();
    chk("load_kept", s_instr, 32'h12345678);

    lm = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) lm = ~lm;
      r  = $urandom;
      la = 9'(r);
      if (r[11:9] != 0) la[1:0] = 2'b00;
      r  = $urandom;
      ra = 9'(r);
      if (r[11:9] != 0) ra[1:0] = 2'b00;
      if (r[14:12] != 0) ra[8] = 1'b0;
      step(lm, 1'($urandom), la, $urandom,
           1'($urandom_range(0, 3) != 0), ra,
           1'($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    b2.load_mode = 1;
    @(negedge clk);
    b2.load_we   = 1;
    b2.load_addr = 10'h3fc;
    b2.load_data = 32'ha5a50ff0;
    #1 chk("big_busy", b2.busy, 1);
    @(negedge clk);
    b2.load_addr = 10'h3fe;
    b2.load_data = 32'h11111111;
    #1 chk("big_lerr0", b2.load_err, 0);
    @(negedge clk);
    b2.load_we   = 0;
    b2.load_mode = 0;
    #1 chk("big_lerr1", b2.load_err, 1);
    @(negedge clk);
    b2.req_valid = 1;
    b2.req_addr  = 10'h3fc;
    b2.rsp_ready = 1;
    #1 chk("big_ready", b2.req_ready, 1);
    @(negedge clk);
    b2.req_addr = 10'h3fe;
    #1;
    chk("big_last", b2.rsp_instr, 32'ha5a50ff0);
    chk("big_last_err", b2.rsp_err, 0);
    chk("big_last_vld", b2.rsp_valid, 1);
    @(negedge clk);
    b2.req_valid = 0;
    #1;
    chk("big_mis", b2.rsp_instr, NOP);
    chk("big_mis_err", b2.rsp_err, 1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
